// File: rtl/bullet_scheduler.sv
// Per-tank bullet-slot scheduler: turns fire requests into one-hot create pulses with
// per-slot lifetimes and a shot cooldown. Define BULLET_AUTOFIRE_EN for held-key autofire.

module bullet_slot #(
  parameter int LIFE_FRAMES = 240
) (
  input  logic frame_clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic load,
  input  logic hit,
  output logic active
);
  localparam int LW = $clog2(LIFE_FRAMES + 1);

  logic [LW-1:0] life_q, life_d;
  logic          active_q, active_d;

  // Load only happens on an inactive slot; hit and expiry collapse into one free.
  always_comb begin
    active_d = active_q;
    life_d   = life_q;
    if (clear) begin
      active_d = 1'b0;
      life_d   = '0;
    end else if (load) begin
      active_d = 1'b1;
      life_d   = LW'(LIFE_FRAMES - 1);
    end else if (active_q) begin
      if (hit || life_q == '0) begin
        active_d = 1'b0;
        life_d   = '0;
      end else begin
        life_d = life_q - 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_q <= 1'b0;
      life_q   <= '0;
    end else begin
      active_q <= active_d;
      life_q   <= life_d;
    end
  end

  assign active = active_q;
endmodule

module bullet_scheduler #(
  parameter int NUM_SLOTS       = 3,
  parameter int LIFE_FRAMES     = 240,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                               frame_clk,
  input  logic                               Reset_n,
  input  logic                               fire,
  input  logic                               tank_alive,
  input  logic                               round_clear,
  input  logic [NUM_SLOTS-1:0]               hit,
  output logic [NUM_SLOTS-1:0]               create,
  output logic [NUM_SLOTS-1:0]               slot_active,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     free_count,
  output logic                               ready,
  output logic                               shot_denied
);
  localparam int FW = $clog2(NUM_SLOTS + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic {READY = 1'b0, COOLDOWN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cd_q, cd_d;
  logic                  fire_q, fire_d;
  logic [NUM_SLOTS-1:0]  create_q, create_d;
  logic                  denied_q, denied_d;
  logic [NUM_SLOTS-1:0]  alloc;
  logic [FW-1:0]         n_active;
  logic                  found, req, accept, deny;

`ifdef BULLET_AUTOFIRE_EN
  assign req = fire;
`else
  assign req = fire & ~fire_q;
`endif

  always_comb begin
    n_active = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n_active = n_active + FW'(slot_active[i]);
  end
  assign free_count = FW'(NUM_SLOTS) - n_active;

  // Lowest-index free slot, taken from registered occupancy so a slot
  // freeing this cycle is not handed out until the next one.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign accept = req & (state_q == READY) & tank_alive & (free_count != '0) & ~round_clear;
  assign deny   = req & (state_q == READY) & tank_alive & (free_count == '0) & ~round_clear;

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    create_d = accept ? alloc : '0;
    denied_d = deny;
    fire_d   = fire & ~round_clear;
    if (round_clear) begin
      state_d = READY;
      cd_d    = '0;
    end else if (state_q == READY) begin
      if (accept) begin
        state_d = COOLDOWN;
        cd_d    = CW'(COOLDOWN_FRAMES - 1);
      end
    end else if (cd_q == '0) begin
      state_d = READY;
    end else begin
      cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= READY;
      cd_q     <= '0;
      fire_q   <= 1'b0;
      create_q <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      fire_q   <= fire_d;
      create_q <= create_d;
      denied_q <= denied_d;
    end
  end

  bullet_slot #(.LIFE_FRAMES(LIFE_FRAMES)) u_slot [NUM_SLOTS-1:0] (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .clear     (round_clear),
    .load      (create_d),
    .hit       (hit),
    .active    (slot_active)
  );

  assign create      = create_q;
  assign shot_denied = denied_q;
  assign ready       = (state_q == READY);
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler at default parameters (3 slots, 240 life, 15 cooldown).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.

module tb_bullet_scheduler;
  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       fire, tank_alive, round_clear;
  logic [2:0] hit, create, slot_active;
  logic [1:0] free_count;
  logic       ready, shot_denied;
  int         n_run  = 0;
  int         n_fail = 0;

  bullet_scheduler dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .fire        (fire),
    .tank_alive  (tank_alive),
    .round_clear (round_clear),
    .hit         (hit),
    .create      (create),
    .slot_active (slot_active),
    .free_count  (free_count),
    .ready       (ready),
    .shot_denied (shot_denied)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b0; fire = 1'b0; tank_alive = 1'b1; round_clear = 1'b0; hit = '0;
    #2;
    chk("rst_create", create, 0);
    chk("rst_active", slot_active, 0);
    chk("rst_denied", shot_denied, 0);
    chk("rst_ready", ready, 1);
    chk("rst_free", free_count, 3);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    // basic shot at edge k0
    fire = 1'b1;
    tick();
    chk("shot0_create", create, 3'b001);
    chk("shot0_active", slot_active, 3'b001);
    chk("shot0_ready", ready, 0);
    chk("shot0_free", free_count, 2);
    fire = 1'b0;
    tick();
    chk("shot0_pulse_end", create, 3'b000);
    chk("shot0_still_active", slot_active, 3'b001);
    repeat (13) tick();
    chk("cd_last_cycle", ready, 0);
    tick();
    chk("cd_done_ready", ready, 1);

    // second shot at k0+16, then a request 5 cycles later is dropped silently
    fire = 1'b1;
    tick();
    chk("shot1_create", create, 3'b010);
    chk("shot1_active", slot_active, 3'b011);
    fire = 1'b0;
    repeat (4) tick();
    fire = 1'b1;
    tick();
    chk("cd_drop_create", create, 3'b000);
    chk("cd_drop_denied", shot_denied, 0);
    chk("cd_drop_active", slot_active, 3'b011);
    fire = 1'b0;
    repeat (10) tick();
    chk("cd1_ready", ready, 1);

    // third shot at k0+32 fills every slot
    fire = 1'b1;
    tick();
    chk("shot2_create", create, 3'b100);
    chk("shot2_free", free_count, 0);
    fire = 1'b0;
    repeat (15) tick();
    chk("cd2_ready", ready, 1);

    // fourth request with no free slot: denial at k0+48
    fire = 1'b1;
    tick();
    chk("deny_pulse", shot_denied, 1);
    chk("deny_create", create, 3'b000);
    chk("deny_ready", ready, 1);
    fire = 1'b0;
    tick();
    chk("deny_pulse_end", shot_denied, 0);

    // hit slot 1, ignored hit on the now-inactive slot, then reuse
    hit = 3'b010;
    tick();
    chk("hit_active", slot_active, 3'b101);
    chk("hit_free", free_count, 1);
    tick();
    chk("hit_inactive_ignored", slot_active, 3'b101);
    hit = 3'b000;
    fire = 1'b1;
    tick();
    chk("reuse_create", create, 3'b010);
    chk("reuse_active", slot_active, 3'b111);
    fire = 1'b0;

    // slot 0 lives exactly 240 cycles (k0..k0+239); request on its expiry edge is denied
    repeat (187) tick();
    chk("life_last_cycle", slot_active, 3'b111);
    fire = 1'b1;
    tick();
    chk("life_expired", slot_active, 3'b110);
    chk("free_and_req_deny", shot_denied, 1);
    chk("free_and_req_create", create, 3'b000);
    fire = 1'b0;
    tick();
    chk("after_expiry_free", free_count, 1);

    // slot 2 (created k0+32) expires at k0+272 together with a hit
    repeat (30) tick();
    chk("pre_hit_expiry", slot_active, 3'b110);
    hit = 3'b100;
    tick();
    chk("hit_and_expiry", slot_active, 3'b010);
    hit = 3'b000;
    repeat (19) tick();
    chk("slot1_last_cycle", slot_active, 3'b010);
    tick();
    chk("all_expired", slot_active, 3'b000);
    chk("all_free", free_count, 3);

    // round_clear during cooldown with a rising fire in the same cycle
    fire = 1'b1;
    tick();
    chk("pre_clear_create", create, 3'b001);
    fire = 1'b0;
    repeat (2) tick();
    round_clear = 1'b1;
    fire = 1'b1;
    tick();
    chk("clear_active", slot_active, 3'b000);
    chk("clear_create", create, 3'b000);
    chk("clear_ready", ready, 1);
    chk("clear_denied", shot_denied, 0);
    round_clear = 1'b0;
    tick();
    chk("post_clear_edge_shot", create, 3'b001);
    fire = 1'b0;
    repeat (15) tick();
    chk("cd3_ready", ready, 1);

    // tank dead: request dropped silently
    tank_alive = 1'b0;
    fire = 1'b1;
    tick();
    chk("dead_create", create, 3'b000);
    chk("dead_denied", shot_denied, 0);
    fire = 1'b0;
    tank_alive = 1'b1;
    tick();
    fire = 1'b1;
    tick();
    chk("pre_reset_create", create, 3'b010);
    chk("pre_reset_active", slot_active, 3'b011);
    fire = 1'b0;

    // asynchronous reset mid-cycle, mid-flight and mid-cooldown
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_create", create, 0);
    chk("async_rst_active", slot_active, 0);
    chk("async_rst_ready", ready, 1);
    chk("async_rst_free", free_count, 3);
    chk("async_rst_denied", shot_denied, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    chk("release_no_create", create, 0);
    chk("release_active", slot_active, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
